// File: rtl/la_checkpoint_monitor_pkg.sv
// Shared types and helpers for the checkpoint monitor and its stability filter.
package la_checkpoint_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_e;

  localparam int unsigned STAB_CW = 4;

  function automatic int unsigned chk_idx_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/la_checkpoint_monitor_stable_filter.sv
// Registers the observation bus and counts consecutive identical samples,
// flagging the registered sample as stable once the count saturates.
module la_stable_filter
  import la_checkpoint_monitor_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] obs,
  output logic             stable,
  output logic [WIDTH-1:0] sample,
  output logic             changed
);

  localparam logic [STAB_CW-1:0] SAT = STAB_CW'(STABLE_CYCLES);

  logic [WIDTH-1:0]   obs_q;
  logic [STAB_CW-1:0] cnt_q, cnt_d;
  logic               chg_q;

  always_comb begin
    cnt_d = 4'd1;
    if (obs == obs_q) begin
      cnt_d = (cnt_q >= SAT) ? SAT : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      obs_q <= '0;
      cnt_q <= '0;
      chg_q <= 1'b0;
    end else begin
      obs_q <= obs;
      cnt_q <= cnt_d;
      chg_q <= (obs != obs_q);
    end
  end

  assign stable  = (cnt_q == SAT);
  assign sample  = obs_q;
  // Pulses for one cycle after a new value was captured; lets the top
  // re-enable matching even when STABLE_CYCLES is 1.
  assign changed = chg_q;

endmodule

// File: rtl/la_checkpoint_monitor.sv
// Checkpoint sequencer: matches filtered observation values against an ordered
// list, reporting progress, pass, ordering failures and timeouts.
module la_checkpoint_monitor
  import la_checkpoint_monitor_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned NUM_CHK        = 4,
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 75000,
  parameter int unsigned TW             = 17,
  parameter int unsigned STRICT         = 1,
  parameter int unsigned PER_STEP_TO    = 0
) (
  input  logic                             clock,
  input  logic                             resetb,
  input  logic                             enable,
  input  logic [WIDTH-1:0]                 obs,
  input  logic [NUM_CHK*WIDTH-1:0]         chk_values,
  input  logic [chk_idx_w(NUM_CHK)-1:0]    chk_count,
  output logic                             started,
  output logic [chk_idx_w(NUM_CHK)-1:0]    progress,
  output logic                             passed,
  output logic                             failed,
  output logic                             timeout,
  output logic [chk_idx_w(NUM_CHK)-1:0]    fail_idx
);

  localparam int unsigned    CW      = chk_idx_w(NUM_CHK);
  localparam logic [CW-1:0]  MAX_CNT = CW'(NUM_CHK);
  localparam logic [TW-1:0]  TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   prog_q, prog_d;
  logic [CW-1:0]   fidx_q, fidx_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            started_q, started_d;
  logic            to_flag_q, to_flag_d;
  logic            consumed_q, consumed_d;

  logic             stable, changed;
  logic [WIDTH-1:0] sample;

  la_stable_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock   (clock),
    .resetb  (resetb),
    .obs     (obs),
    .stable  (stable),
    .sample  (sample),
    .changed (changed)
  );

  logic [WIDTH-1:0] chk [NUM_CHK];
  logic [WIDTH-1:0] cur_val;
  logic             later_hit, hit_cur, viol, to_hit;
  logic [CW-1:0]    prog_inc;

  always_comb begin
    cur_val   = '0;
    later_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      chk[i] = chk_values[i*WIDTH +: WIDTH];
      if (CW'(i) == prog_q) cur_val = chk[i];
      if (CW'(i) > prog_q && CW'(i) < count_q && chk[i] == sample) later_hit = 1'b1;
    end
  end

  // A value that just matched stays consumed until the filter sees a change,
  // so a held value neither re-matches nor trips the ordering check.
  assign hit_cur  = stable && !consumed_q && (sample == cur_val);
  assign viol     = (STRICT != 0) && stable && !consumed_q && later_hit && !hit_cur;
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (tcnt_q >= TO_LAST);
  assign prog_inc = prog_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prog_d     = prog_q;
    fidx_d     = fidx_q;
    tcnt_d     = tcnt_q;
    started_d  = started_q;
    to_flag_d  = to_flag_q;
    consumed_d = changed ? 1'b0 : consumed_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = ARMED;
          count_d    = (chk_count > MAX_CNT) ? MAX_CNT : chk_count;
          prog_d     = '0;
          fidx_d     = '0;
          tcnt_d     = '0;
          started_d  = 1'b0;
          to_flag_d  = 1'b0;
          consumed_d = 1'b0;
        end
      end
      ARMED: begin
        if (count_q == '0) begin
          state_d = PASS;
        end else if (hit_cur) begin
          prog_d     = prog_inc;
          started_d  = 1'b1;
          consumed_d = 1'b1;
          if (PER_STEP_TO != 0) tcnt_d = '0;
          else if (!to_hit)     tcnt_d = tcnt_q + 1'b1;
          if (prog_inc == count_q) state_d = PASS;
        end else if (viol) begin
          state_d = FAIL;
          fidx_d  = prog_q;
        end else if (to_hit) begin
          state_d   = FAIL;
          to_flag_d = 1'b1;
          fidx_d    = prog_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (!enable) begin
      state_d    = IDLE;
      prog_d     = '0;
      fidx_d     = '0;
      tcnt_d     = '0;
      started_d  = 1'b0;
      to_flag_d  = 1'b0;
      consumed_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      count_q    <= '0;
      prog_q     <= '0;
      fidx_q     <= '0;
      tcnt_q     <= '0;
      started_q  <= 1'b0;
      to_flag_q  <= 1'b0;
      consumed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prog_q     <= prog_d;
      fidx_q     <= fidx_d;
      tcnt_q     <= tcnt_d;
      started_q  <= started_d;
      to_flag_q  <= to_flag_d;
      consumed_q <= consumed_d;
    end
  end

  assign started  = started_q;
  assign progress = prog_q;
  assign passed   = (state_q == PASS);
  assign failed   = (state_q == FAIL);
  assign timeout  = to_flag_q;
  assign fail_idx = fidx_q;

endmodule

// File: tb/tb_la_checkpoint_monitor.sv
// Directed bench: two monitors (global and per-step timeout, 100-cycle limit)
// share stimulus; vectors and hand sequences carry hand-computed expectations.
module tb_la_checkpoint_monitor;

  logic        clock = 1'b0;
  logic        resetb;
  logic        enable;
  logic [15:0] obs;
  logic [63:0] chk_values;
  logic [2:0]  chk_count;

  logic       a_st, a_ps, a_fl, a_to;
  logic [2:0] a_pg, a_fi;
  logic       b_st, b_ps, b_fl, b_to;
  logic [2:0] b_pg, b_fi;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  la_checkpoint_monitor #(
    .WIDTH(16), .NUM_CHK(4), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(100),
    .TW(17), .STRICT(1), .PER_STEP_TO(0)
  ) dut_a (
    .clock(clock), .resetb(resetb), .enable(enable), .obs(obs),
    .chk_values(chk_values), .chk_count(chk_count),
    .started(a_st), .progress(a_pg), .passed(a_ps), .failed(a_fl),
    .timeout(a_to), .fail_idx(a_fi)
  );

  la_checkpoint_monitor #(
    .WIDTH(16), .NUM_CHK(4), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(100),
    .TW(17), .STRICT(1), .PER_STEP_TO(1)
  ) dut_b (
    .clock(clock), .resetb(resetb), .enable(enable), .obs(obs),
    .chk_values(chk_values), .chk_count(chk_count),
    .started(b_st), .progress(b_pg), .passed(b_ps), .failed(b_fl),
    .timeout(b_to), .fail_idx(b_fi)
  );

  localparam logic [63:0] V2 = {16'h0000, 16'h0000, 16'hAB61, 16'hAB60};
  localparam logic [63:0] VD = {16'h0000, 16'h0000, 16'hAB60, 16'hAB60};
  localparam logic [63:0] V3 = {16'h0000, 16'hAB62, 16'hAB61, 16'hAB60};
  localparam logic [63:0] V4 = {16'hAB63, 16'hAB62, 16'hAB61, 16'hAB60};

  typedef struct {
    logic        en;
    logic [2:0]  cnt;
    logic [63:0] vals;
    logic [15:0] o;
    logic        st;
    logic [2:0]  pg;
    logic        ps;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [2:0] cnt, input logic [63:0] vals,
                              input logic [15:0] o, input logic st, input logic [2:0] pg,
                              input logic ps);
    vec_t v;
    v.en = en; v.cnt = cnt; v.vals = vals; v.o = o; v.st = st; v.pg = pg; v.ps = ps;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic st, input logic [2:0] pg,
                           input logic ps, input logic fl, input logic to,
                           input logic [2:0] fi);
    chk1({nm, ".A.started"},  32'(a_st), 32'(st));
    chk1({nm, ".A.progress"}, 32'(a_pg), 32'(pg));
    chk1({nm, ".A.passed"},   32'(a_ps), 32'(ps));
    chk1({nm, ".A.failed"},   32'(a_fl), 32'(fl));
    chk1({nm, ".A.timeout"},  32'(a_to), 32'(to));
    chk1({nm, ".A.fail_idx"}, 32'(a_fi), 32'(fi));
    chk1({nm, ".B.started"},  32'(b_st), 32'(st));
    chk1({nm, ".B.progress"}, 32'(b_pg), 32'(pg));
    chk1({nm, ".B.passed"},   32'(b_ps), 32'(ps));
    chk1({nm, ".B.failed"},   32'(b_fl), 32'(fl));
    chk1({nm, ".B.timeout"},  32'(b_to), 32'(to));
    chk1({nm, ".B.fail_idx"}, 32'(b_fi), 32'(fi));
  endtask

  task automatic step(input logic en_v, input logic [15:0] obs_v);
    enable = en_v;
    obs    = obs_v;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] v4w;
    v4w = V4;

    // Basic pass, glitch rejection, duplicate checkpoints (one vector per edge)
    tbl.push_back(mk(1, 2, V2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB60, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB60, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB60, 1, 1, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB61, 1, 1, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB61, 1, 1, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB61, 1, 2, 1));
    tbl.push_back(mk(1, 2, V2, 16'hAB61, 1, 2, 1));
    tbl.push_back(mk(0, 2, V2, 16'hAB61, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'hAB60, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, V2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 2, V2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, VD, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 0, 0, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 0, 0, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 1, 1, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 1, 1, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 1, 1, 0));
    tbl.push_back(mk(1, 2, VD, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 1, 1, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 1, 1, 0));
    tbl.push_back(mk(1, 2, VD, 16'hAB60, 1, 2, 1));
    tbl.push_back(mk(0, 2, VD, 16'h0000, 0, 0, 0));

    resetb     = 1'b0;
    enable     = 1'b0;
    obs        = '0;
    chk_values = '0;
    chk_count  = '0;
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    resetb = 1'b1;
    step(0, 16'h0000);
    step(0, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      chk_values = tbl[i].vals;
      chk_count  = tbl[i].cnt;
      step(tbl[i].en, tbl[i].o);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pg, tbl[i].ps, 0, 0, 0);
    end

    // Ordering violation: AB62 stable while waiting for AB61
    chk_values = V3;
    chk_count  = 3'd3;
    step(1, 16'h0000);
    repeat (3) step(1, 16'hAB60);
    check_all("strict.first", 1, 1, 0, 0, 0, 0);
    repeat (2) step(1, 16'hAB62);
    check_all("strict.settling", 1, 1, 0, 0, 0, 0);
    step(1, 16'hAB62);
    check_all("strict.fail", 1, 1, 0, 1, 0, 1);
    step(0, 16'h0000);
    check_all("strict.disarm", 0, 0, 0, 0, 0, 0);

    // Timeout with no activity: fires on the 100th armed edge
    chk_values = V2;
    chk_count  = 3'd2;
    step(1, 16'h0000);
    repeat (99) step(1, 16'h0000);
    check_all("to.before", 0, 0, 0, 0, 0, 0);
    step(1, 16'h0000);
    check_all("to.hit", 0, 0, 0, 1, 1, 0);
    step(0, 16'h0000);

    // Matches 80 cycles apart: per-step passes, global times out after first
    chk_values = V4;
    chk_count  = 3'd4;
    step(1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      repeat (77) step(1, 16'h0000);
      repeat (3) step(1, v4w[k*16 +: 16]);
    end
    chk1("perstep.B.passed",   32'(b_ps), 32'd1);
    chk1("perstep.B.failed",   32'(b_fl), 32'd0);
    chk1("perstep.B.progress", 32'(b_pg), 32'd4);
    chk1("global.A.failed",    32'(a_fl), 32'd1);
    chk1("global.A.timeout",   32'(a_to), 32'd1);
    chk1("global.A.fail_idx",  32'(a_fi), 32'd1);
    chk1("global.A.progress",  32'(a_pg), 32'd1);
    step(0, 16'h0000);
    check_all("perstep.disarm", 0, 0, 0, 0, 0, 0);

    // Disarm mid-run, re-arm to PASS, async reset, then empty list
    chk_values = V2;
    chk_count  = 3'd2;
    step(1, 16'h0000);
    repeat (3) step(1, 16'hAB60);
    check_all("midrun.prog1", 1, 1, 0, 0, 0, 0);
    step(0, 16'hAB60);
    check_all("midrun.disarm", 0, 0, 0, 0, 0, 0);
    chk_count = 3'd1;
    step(1, 16'hAB60);
    check_all("rearm.armed", 0, 0, 0, 0, 0, 0);
    step(1, 16'hAB60);
    check_all("rearm.pass", 1, 1, 1, 0, 0, 0);
    @(negedge clock);
    resetb = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0);
    chk_count = 3'd0;
    @(negedge clock);
    resetb = 1'b1;
    @(posedge clock);
    #1;
    check_all("zero.armed", 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    check_all("zero.pass", 0, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
